bridge_frame_executor: RTL and testbench
========================================

BRIDGE_FRAME_EXECUTOR -- requirements
Module: bridge_frame_executor

Interface
REQ-001 Parameter DATA_WIDTH, 8, data width of bus transactions.
REQ-002 Parameter ADDR_WIDTH, 12, address width of bus transactions.
REQ-003 Parameter FIFO_DEPTH, 4, number of buffered frames (power of two, 2..16).
REQ-004 Parameter TIMEOUT_CYCLES, 255, cycles before a transaction aborts (TIMEOUT_EN builds only).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 rx_ready  input  1  one-cycle pulse; rx_frame is valid.
REQ-008 rx_frame  input  DATA_WIDTH+ADDR_WIDTH+1  frame from UART RX: [ADDR_WIDTH-1:0] addr, next DATA_WIDTH bits wdata, MSB mode (1 write, 0 read).
REQ-009 tx_data  output  DATA_WIDTH  read data for UART TX.
REQ-010 tx_en  output  1  one-cycle pulse that starts a UART TX transfer.
REQ-011 tx_busy  input  1  UART TX busy.
REQ-012 m_req  output  1  transaction request to the master port; held until acknowledged.
REQ-013 m_mode, m_addr, m_wdata  output  1/ADDR_WIDTH/DATA_WIDTH  transaction fields; stable while m_req=1.
REQ-014 m_ack  input  1  one-cycle completion pulse from the master port.
REQ-015 m_rdata  input  DATA_WIDTH  read data; valid when m_ack=1.
REQ-016 overflow  output  1  sticky flag: a frame was dropped.
REQ-017 fifo_count  output  $clog2(FIFO_DEPTH)+1  frames currently buffered.

Function
REQ-018 The block SHALL write rx_frame into the FIFO on rx_ready when fifo_count<FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-019 When the FIFO is full, rx_ready SHALL drop the frame and set overflow; this holds even if a pop occurs in the same cycle.
REQ-020 FSM states: IDLE, ISSUE, RESP, RWAIT.
REQ-021 IDLE: if the FIFO is non-empty, pop the head into m_mode/m_addr/m_wdata and go to ISSUE; otherwise stay.
REQ-022 ISSUE: m_req=1; on m_ack, go to IDLE for a write, or capture m_rdata into tx_data and go to RESP for a read.
REQ-023 m_req SHALL be 0 in the cycle after m_ack is sampled.
REQ-024 m_ack outside ISSUE SHALL be ignored.
REQ-025 RESP: when tx_busy=0, pulse tx_en for exactly one cycle and go to RWAIT; otherwise stay with tx_en=0.
REQ-026 RWAIT: stay until tx_busy=1 is sampled, then go to IDLE; this prevents a second tx_en before the UART accepts the first.
REQ-027 Latency: rx_ready in cycle N with the FIFO empty and the FSM in IDLE SHALL give m_req=1 in cycle N+2.
REQ-028 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve frame order.
REQ-029 Frames SHALL be executed strictly in arrival order, one outstanding transaction at a time.

Reset
REQ-030 With rstn=0 at a clock edge, the block SHALL enter IDLE and empty the FIFO.
REQ-031 During that reset, m_req, tx_en, overflow and fifo_count SHALL be 0, and tx_data, m_addr, m_wdata and m_mode SHALL be all-zero.
REQ-032 Reset during ISSUE, RESP or RWAIT SHALL abandon the transaction with no further tx_en or m_req.

Configuration
REQ-033 Macro FRAME_EXEC_TIMEOUT_EN defined: a counter SHALL run in ISSUE, restarting on entry.
REQ-034 On reaching TIMEOUT_CYCLES without m_ack, m_req SHALL drop; a write returns to IDLE, and a read loads tx_data={DATA_WIDTH{1'b1}} and goes to RESP.
REQ-035 Macro FRAME_EXEC_TIMEOUT_EN undefined: ISSUE SHALL wait for m_ack indefinitely, and no counter logic SHALL be present.

Verification
REQ-036 Write frame {1,8'hA5,12'h123}, m_ack 3 cycles after m_req -> m_req at N+2 with m_addr=12'h123, m_wdata=8'hA5, m_mode=1; tx_en never asserted.
REQ-037 Read frame addr 12'h0F0, m_ack with m_rdata=8'h3C, tx_busy low -> one tx_en pulse with tx_data=8'h3C; FSM returns to IDLE after tx_busy rises.
REQ-038 Six back-to-back frames while m_ack is withheld -> fifo_count peaks at 4 with FIFO_DEPTH=4; overflow=1 after the frame that arrives while full; the remaining frames execute in order.
REQ-039 Read completes while tx_busy=1 for 20 cycles -> tx_en asserted only in the cycle after tx_busy falls, exactly once.
REQ-040 FRAME_EXEC_TIMEOUT_EN build, read with no m_ack -> m_req drops after 255 cycles; tx_en pulses with tx_data=8'hFF.
REQ-041 rstn=0 asserted mid-ISSUE with 2 frames queued -> next cycle m_req=0, fifo_count=0, overflow=0; no tx_en afterwards.

Source files
------------

// File: rtl/bridge_frame_executor_if.sv
// Bundle of UART-side frame/response signals and master-port transaction bus
// for bridge_frame_executor; "master" is the executor side, "slave" its environment.
interface bridge_frame_executor_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
);
  logic                          rx_ready;
  logic [DATA_WIDTH+ADDR_WIDTH:0] rx_frame;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_en;
  logic                          tx_busy;
  logic                          m_req;
  logic                          m_mode;
  logic [ADDR_WIDTH-1:0]         m_addr;
  logic [DATA_WIDTH-1:0]         m_wdata;
  logic                          m_ack;
  logic [DATA_WIDTH-1:0]         m_rdata;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    input  rx_ready, rx_frame, tx_busy, m_ack, m_rdata,
    output tx_data, tx_en, m_req, m_mode, m_addr, m_wdata, overflow, fifo_count
  );

  modport slave (
    output rx_ready, rx_frame, tx_busy, m_ack, m_rdata,
    input  tx_data, tx_en, m_req, m_mode, m_addr, m_wdata, overflow, fifo_count
  );
endinterface

// File: rtl/bridge_frame_executor.sv
// Buffers UART frames in a FIFO and executes them one at a time on the master port,
// returning read data to UART TX. Optional ISSUE timeout: FRAME_EXEC_TIMEOUT_EN.
module bridge_frame_executor #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  bridge_frame_executor_if.master  bus
);

  localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_RWAIT} state_e;

  state_e                state_q;
  logic [FW-1:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, push, pop, tmo_hit;
  logic [FW-1:0]         head;
  logic                  overflow_q, m_req_q, m_mode_q, tx_en_q;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic [DATA_WIDTH-1:0] m_wdata_q, tx_data_q;

  // Drop decision uses the pre-pop count, so a pop in the same cycle cannot make room.
  always_comb begin
    full    = (count_q == CW'(FIFO_DEPTH));
    push    = bus.rx_ready && !full;
    pop     = (state_q == S_IDLE) && (count_q != '0);
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.rx_frame;
  end

`ifdef FRAME_EXEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  // Popping is the only way into ISSUE, so it doubles as the restart.
  always_ff @(posedge clk) begin
    if (!rstn || pop)             tmo_q <= '0;
    else if (state_q == S_ISSUE) tmo_q <= tmo_q + TW'(1);
  end

  assign tmo_hit = (state_q == S_ISSUE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      m_req_q    <= 1'b0;
      m_mode_q   <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (bus.rx_ready && full) overflow_q <= 1'b1;
      tx_en_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            m_mode_q  <= head[FW-1];
            m_addr_q  <= head[ADDR_WIDTH-1:0];
            m_wdata_q <= head[ADDR_WIDTH +: DATA_WIDTH];
            m_req_q   <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.m_ack) begin
            m_req_q <= 1'b0;
            if (m_mode_q) begin
              state_q <= S_IDLE;
            end else begin
              tx_data_q <= bus.m_rdata;
              state_q   <= S_RESP;
            end
          end else if (tmo_hit) begin
            m_req_q <= 1'b0;
            if (m_mode_q) begin
              state_q <= S_IDLE;
            end else begin
              tx_data_q <= '1;
              state_q   <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (!bus.tx_busy) begin
            tx_en_q <= 1'b1;
            state_q <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (bus.tx_busy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_en      = tx_en_q;
  assign bus.m_req      = m_req_q;
  assign bus.m_mode     = m_mode_q;
  assign bus.m_addr     = m_addr_q;
  assign bus.m_wdata    = m_wdata_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_bridge_frame_executor.sv
// Directed scoreboard bench for bridge_frame_executor: expected transactions and
// TX bytes are queued at stimulus time and checked when the DUT produces them.
module tb_bridge_frame_executor;

  typedef struct packed {
    logic        mode;
    logic [11:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  logic clk;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;
  txn_t exp_txn[$];
  logic [7:0] exp_tx[$];
  logic mreq_prev;

  bridge_frame_executor_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .FIFO_DEPTH(4)) bus ();

  bridge_frame_executor #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(255)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic mode, input logic [11:0] addr, input logic [7:0] wdata);
    bus.rx_frame = {mode, wdata, addr};
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
  endtask

  task automatic ack(input logic [7:0] rdata);
    bus.m_rdata = rdata;
    bus.m_ack   = 1'b1;
    tick();
    bus.m_ack   = 1'b0;
  endtask

  task automatic wait_mreq(input int budget);
    int k = 0;
    while (!bus.m_req && k < budget) begin
      tick();
      k++;
    end
    chk("wait_mreq", bus.m_req, 1);
  endtask

  task automatic tx_busy_pulse();
    bus.tx_busy = 1'b1;
    tick();
    bus.tx_busy = 1'b0;
    tick();
  endtask

  // Scoreboard side: new transactions and TX pulses are matched against the queues.
  always @(negedge clk) begin
    if (!rstn) begin
      mreq_prev <= 1'b0;
    end else begin
      if (bus.m_req && !mreq_prev) begin
        if (exp_txn.size() == 0) begin
          chk("unexpected_m_req", bus.m_req, 0);
        end else begin
          txn_t e;
          e = exp_txn.pop_front();
          chk("m_mode", bus.m_mode, e.mode);
          chk("m_addr", bus.m_addr, e.addr);
          chk("m_wdata", bus.m_wdata, e.wdata);
        end
      end
      mreq_prev <= bus.m_req;
      if (bus.tx_en) begin
        if (exp_tx.size() == 0) chk("unexpected_tx_en", bus.tx_en, 0);
        else                    chk("tx_data", bus.tx_data, exp_tx.pop_front());
      end
    end
  end

  initial begin
    int cnt_exp [6] = '{1, 1, 2, 3, 4, 4};
    int hi;
    rstn = 1'b0;
    bus.rx_ready = 1'b0;
    bus.rx_frame = '0;
    bus.tx_busy  = 1'b0;
    bus.m_ack    = 1'b0;
    bus.m_rdata  = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_tx_en", bus.tx_en, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_fifo_count", bus.fifo_count, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_m_mode", bus.m_mode, 0);
    rstn = 1'b1;
    tick();

    // Single write: latency N+2, ack three cycles later, no TX
    exp_txn.push_back('{1'b1, 12'h123, 8'hA5});
    send_frame(1'b1, 12'h123, 8'hA5);
    chk("wr_count_n1", bus.fifo_count, 1);
    chk("wr_mreq_n1", bus.m_req, 0);
    tick();
    chk("wr_mreq_n2", bus.m_req, 1);
    chk("wr_count_n2", bus.fifo_count, 0);
    repeat (2) tick();
    ack(8'h00);
    chk("wr_mreq_after_ack", bus.m_req, 0);
    repeat (3) tick();

    // Single read returning 3C; next frame held back until tx_busy is seen
    exp_txn.push_back('{1'b0, 12'h0F0, 8'h00});
    exp_tx.push_back(8'h3C);
    send_frame(1'b0, 12'h0F0, 8'h00);
    wait_mreq(10);
    ack(8'h3C);
    chk("rd_mreq_after_ack", bus.m_req, 0);
    chk("rd_tx_en_resp", bus.tx_en, 0);
    tick();
    chk("rd_tx_en_pulse", bus.tx_en, 1);
    chk("rd_tx_data", bus.tx_data, 8'h3C);
    repeat (5) tick();
    exp_txn.push_back('{1'b1, 12'h200, 8'h5C});
    send_frame(1'b1, 12'h200, 8'h5C);
    repeat (3) tick();
    chk("rwait_holds_mreq", bus.m_req, 0);
    chk("rwait_holds_count", bus.fifo_count, 1);
    tx_busy_pulse();
    wait_mreq(10);
    ack(8'h00);
    repeat (2) tick();

    // Six back-to-back writes with ack withheld: peak 4, sixth dropped
    for (int i = 0; i < 5; i++) exp_txn.push_back('{1'b1, 12'h300 + 12'(i), 8'h10 + 8'(i)});
    for (int i = 0; i < 6; i++) begin
      send_frame(1'b1, 12'h300 + 12'(i), 8'h10 + 8'(i));
      chk($sformatf("burst_count_%0d", i), bus.fifo_count, cnt_exp[i]);
      chk($sformatf("burst_overflow_%0d", i), bus.overflow, (i == 5) ? 1 : 0);
    end
    wait_mreq(10);
    bus.m_ack = 1'b1;
    tick();
    bus.m_ack    = 1'b0;
    bus.rx_frame = {1'b1, 8'hEE, 12'hEEE};
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    chk("full_push_with_pop_dropped", bus.fifo_count, 3);
    for (int i = 0; i < 4; i++) begin
      wait_mreq(20);
      ack(8'h00);
    end
    repeat (2) tick();
    chk("burst_drained", bus.fifo_count, 0);
    chk("overflow_sticky", bus.overflow, 1);

    // Read completing while tx_busy held for 20 cycles
    bus.tx_busy = 1'b1;
    exp_txn.push_back('{1'b0, 12'h456, 8'h00});
    exp_tx.push_back(8'h77);
    send_frame(1'b0, 12'h456, 8'h00);
    wait_mreq(10);
    ack(8'h77);
    repeat (20) tick();
    chk("busy_no_tx_en", bus.tx_en, 0);
    bus.tx_busy = 1'b0;
    tick();
    chk("busy_release_tx_en", bus.tx_en, 1);
    tick();
    chk("busy_tx_en_single", bus.tx_en, 0);
    tx_busy_pulse();

`ifdef FRAME_EXEC_TIMEOUT_EN
    // Unacknowledged read aborts after 255 cycles with all-ones data
    exp_txn.push_back('{1'b0, 12'h7FF, 8'h00});
    exp_tx.push_back(8'hFF);
    send_frame(1'b0, 12'h7FF, 8'h00);
    wait_mreq(10);
    hi = 0;
    while (bus.m_req && hi < 400) begin
      tick();
      hi++;
    end
    chk("timeout_mreq_cycles", hi, 255);
    tick();
    chk("timeout_tx_en", bus.tx_en, 1);
    chk("timeout_tx_data", bus.tx_data, 8'hFF);
    tx_busy_pulse();
`else
    // Without the timeout build, ISSUE waits for m_ack indefinitely
    exp_txn.push_back('{1'b0, 12'h7FF, 8'h00});
    exp_tx.push_back(8'h5A);
    send_frame(1'b0, 12'h7FF, 8'h00);
    wait_mreq(10);
    hi = 0;
    while (bus.m_req && hi < 300) begin
      tick();
      hi++;
    end
    chk("no_timeout_mreq_held", bus.m_req, 1);
    ack(8'h5A);
    tick();
    chk("no_timeout_tx_en", bus.tx_en, 1);
    tx_busy_pulse();
`endif

    // Reset mid-ISSUE with two frames queued: everything abandoned
    exp_txn.push_back('{1'b1, 12'h0AB, 8'h11});
    send_frame(1'b1, 12'h0AB, 8'h11);
    wait_mreq(10);
    send_frame(1'b0, 12'h0AC, 8'h00);
    send_frame(1'b1, 12'h0AD, 8'h22);
    chk("pre_reset_count", bus.fifo_count, 2);
    chk("pre_reset_overflow", bus.overflow, 1);
    rstn = 1'b0;
    tick();
    chk("mid_rst_m_req", bus.m_req, 0);
    chk("mid_rst_count", bus.fifo_count, 0);
    chk("mid_rst_overflow", bus.overflow, 0);
    rstn = 1'b1;
    repeat (10) tick();
    chk("post_rst_m_req", bus.m_req, 0);
    chk("post_rst_tx_en", bus.tx_en, 0);

    chk("txn_queue_empty", exp_txn.size(), 0);
    chk("tx_queue_empty", exp_tx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
